// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 control units: FSM states,
// opcode match patterns, ALU operand/operation selects and instruction classes.
package legv8_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_WB_R   = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WB = 4'd7,
      S_MEM_WR = 4'd8,
      S_CB     = 4'd9,
      S_B      = 4'd10,
      S_FAULT  = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      C_NOP  = 3'd0,
      C_R    = 3'd1,
      C_LDUR = 3'd2,
      C_STUR = 3'd3,
      C_CB   = 3'd4,
      C_B    = 3'd5,
      C_ILL  = 3'd6
   } iclass_t;

   // R-type checks bit 10, bits 7:4 and bits 2:0 only
   localparam logic [10:0] R_MASK     = 11'b10011110111;
   localparam logic [10:0] R_MATCH    = 11'b10001010000;
   localparam logic [10:0] OP_STUR    = 11'b11111000000;
   localparam logic [10:0] OP_LDUR    = 11'b11111000010;
   localparam logic [10:0] CB_MASK    = 11'b11111111000;
   localparam logic [10:0] CBZ_MATCH  = 11'b10110100000;
   localparam logic [10:0] CBNZ_MATCH = 11'b10110101000;
   localparam logic [10:0] B_MASK     = 11'b11111100000;
   localparam logic [10:0] B_MATCH    = 11'b00010100000;

   localparam logic [1:0] ASB_REGB = 2'b00;
   localparam logic [1:0] ASB_FOUR = 2'b01;
   localparam logic [1:0] ASB_DOFF = 2'b10;
   localparam logic [1:0] ASB_BOFF = 2'b11;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_PASSB  = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   function automatic logic op_match(logic [10:0] op, logic [10:0] mask,
                                     logic [10:0] pattern);
      return (op & mask) == pattern;
   endfunction

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational opcode classifier, shared by the single-cycle and multicycle
// control units.
module legv8_opdecode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output iclass_t     cls,
   output logic        illegal,
   output logic        reg2loc,
   output logic        cond_inv
);

   always_comb begin
      cls      = C_ILL;
      reg2loc  = 1'b0;
      cond_inv = 1'b0;
      if (opcode == 11'd0) begin
         cls = C_NOP;
      end else if (op_match(opcode, R_MASK, R_MATCH)) begin
         cls = C_R;
      end else if (opcode == OP_LDUR) begin
         cls = C_LDUR;
      end else if (opcode == OP_STUR) begin
         cls     = C_STUR;
         reg2loc = 1'b1;
      end else if (op_match(opcode, CB_MASK, CBZ_MATCH)) begin
         cls     = C_CB;
         reg2loc = 1'b1;
      end else if (op_match(opcode, CB_MASK, CBNZ_MATCH)) begin
         cls      = C_CB;
         reg2loc  = 1'b1;
         cond_inv = 1'b1;
      end else if (op_match(opcode, B_MASK, B_MATCH)) begin
         cls = C_B;
      end
      illegal = (cls == C_ILL);
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM with memory-ready handshake and timeout,
// illegal-opcode pulse and cycle/retired-instruction counters.
module multicycle_control
   import legv8_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int WAIT_W      = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_cond_inv,
   output logic             pc_src,
   output logic             ior_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             reg2loc,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic             fault,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   // Memory handshake: in S_FETCH/S_MEM_RD/S_MEM_WR the strobes (mem_read or
   // mem_write, ior_d) hold steady until mem_ready is sampled high on a rising
   // edge; that edge completes the access and leaves the state.
   state_t            state_q, state_next;
   logic [WAIT_W-1:0] wait_cnt;
   iclass_t           cls;
   logic              dec_illegal, dec_reg2loc, dec_cond_inv;
   logic              mem_state, timeout_hit, retire;

   legv8_opdecode u_dec (
      .opcode   (opcode),
      .cls      (cls),
      .illegal  (dec_illegal),
      .reg2loc  (dec_reg2loc),
      .cond_inv (dec_cond_inv)
   );

   assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
   assign state       = state_q;

   always_comb begin
      state_next = state_q;
      case (state_q)
         S_RESET:  state_next = S_FETCH;
         S_FETCH: begin
            if (mem_ready)        state_next = S_DECODE;
            else if (timeout_hit) state_next = S_FAULT;
         end
         S_DECODE: begin
            case (cls)
               C_R:          state_next = S_EXEC_R;
               C_LDUR, C_STUR: state_next = S_ADDR;
               C_CB:         state_next = S_CB;
               C_B:          state_next = S_B;
               default:      state_next = S_FETCH;
            endcase
         end
         S_EXEC_R: state_next = S_WB_R;
         S_WB_R:   state_next = S_FETCH;
         S_ADDR: begin
            if (cls == C_LDUR)      state_next = S_MEM_RD;
            else if (cls == C_STUR) state_next = S_MEM_WR;
            else                    state_next = S_FETCH;
         end
         S_MEM_RD: begin
            if (mem_ready)        state_next = S_MEM_WB;
            else if (timeout_hit) state_next = S_FAULT;
         end
         S_MEM_WB: state_next = S_FETCH;
         S_MEM_WR: begin
            if (mem_ready)        state_next = S_FETCH;
            else if (timeout_hit) state_next = S_FAULT;
         end
         S_CB, S_B: state_next = S_FETCH;
         S_FAULT:  state_next = S_FAULT;
         default:  state_next = S_RESET;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_cond_inv   = 1'b0;
      pc_src        = 1'b0;
      ior_d         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ASB_REGB;
      alu_op        = ALU_ADD;
      illegal       = 1'b0;
      fault         = 1'b0;
      retire        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ASB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = ASB_BOFF;
            illegal   = dec_illegal;
            retire    = (cls == C_NOP);
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ASB_DOFF;
         end
         S_MEM_RD: begin
            mem_read  = 1'b1;
            ior_d     = 1'b1;
            mdr_write = mem_ready;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            ior_d     = 1'b1;
            retire    = mem_ready;
         end
         S_CB: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_PASSB;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
            pc_cond_inv   = dec_cond_inv;
            retire        = 1'b1;
         end
         S_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
      reg2loc = dec_reg2loc && (state_q != S_RESET) && (state_q != S_FAULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RESET;
         wait_cnt    <= '0;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         state_q <= state_next;
         // Any exit from, or move between, memory states restarts the count
         if (mem_state && !mem_ready && (state_next == state_q))
            wait_cnt <= wait_cnt + WAIT_W'(1);
         else
            wait_cnt <= '0;
         if (state_q != S_FAULT)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire)
            instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams checked
// against a per-instruction phase model with counter bookkeeping.
module tb_multicycle_control;
   import legv8_ctrl_pkg::*;

   localparam int K_NOP = 0, K_R = 1, K_LDUR = 2, K_STUR = 3, K_CBZ = 4,
                  K_CBNZ = 5, K_B = 6, K_ILL = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] opcode = '0;
   logic        mem_ready = 1'b0;

   logic        pc_write, pc_write_cond, pc_cond_inv, pc_src, ior_d, mem_read;
   logic        mem_write, ir_write, mdr_write, mem_to_reg, reg_write, reg2loc;
   logic        alu_src_a, illegal, fault;
   logic [1:0]  alu_src_b, alu_op;
   logic [3:0]  state;
   logic [3:0]  cycle_cnt, instret_cnt;

   logic        b_pc_write, b_pc_write_cond, b_pc_cond_inv, b_pc_src, b_ior_d;
   logic        b_mem_read, b_mem_write, b_ir_write, b_mdr_write, b_mem_to_reg;
   logic        b_reg_write, b_reg2loc, b_alu_src_a, b_illegal, b_fault;
   logic [1:0]  b_alu_src_b, b_alu_op;
   logic [3:0]  b_state;
   logic [31:0] b_cycle_cnt, b_instret_cnt;

   logic [18:0] obs_outs, obs_outs_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ret      = 0;

   multicycle_control #(.MEM_TIMEOUT(15), .WAIT_W(4), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_cond_inv(pc_cond_inv),
      .pc_src(pc_src), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mdr_write(mdr_write), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .fault(fault),
      .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   multicycle_control u_dut32 (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
      .pc_cond_inv(b_pc_cond_inv), .pc_src(b_pc_src), .ior_d(b_ior_d),
      .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
      .mdr_write(b_mdr_write), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
      .reg2loc(b_reg2loc), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
      .alu_op(b_alu_op), .illegal(b_illegal), .fault(b_fault), .state(b_state),
      .cycle_cnt(b_cycle_cnt), .instret_cnt(b_instret_cnt)
   );

   assign obs_outs = {pc_write, pc_write_cond, pc_cond_inv, pc_src, ior_d, mem_read,
                      mem_write, ir_write, mdr_write, mem_to_reg, reg_write, reg2loc,
                      alu_src_a, alu_src_b, alu_op, illegal, fault};
   assign obs_outs_b = {b_pc_write, b_pc_write_cond, b_pc_cond_inv, b_pc_src, b_ior_d,
                        b_mem_read, b_mem_write, b_ir_write, b_mdr_write, b_mem_to_reg,
                        b_reg_write, b_reg2loc, b_alu_src_a, b_alu_src_b, b_alu_op,
                        b_illegal, b_fault};

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int classify(logic [10:0] op);
      if (op == 11'd0)                return K_NOP;
      if (op ==? 11'b1??0101?000)     return K_R;
      if (op == 11'b11111000010)      return K_LDUR;
      if (op == 11'b11111000000)      return K_STUR;
      if (op ==? 11'b10110100???)     return K_CBZ;
      if (op ==? 11'b10110101???)     return K_CBNZ;
      if (op ==? 11'b000101?????)     return K_B;
      return K_ILL;
   endfunction

   function automatic int base_latency(int k);
      case (k)
         K_R:           return 4;
         K_LDUR:        return 5;
         K_STUR:        return 4;
         K_CBZ, K_CBNZ, K_B: return 3;
         default:       return 2;
      endcase
   endfunction

   function automatic logic [18:0] exp_outs(state_t st, logic rdy, logic [10:0] op);
      logic pw, pwc, pci, ps, iord, mr, mw, irw, mdrw, m2r, rw, r2l, asa, ill, flt;
      logic [1:0] asb, aop;
      int k;
      k = classify(op);
      {pw, pwc, pci, ps, iord, mr, mw, irw, mdrw, m2r, rw, asa, ill, flt} = '0;
      asb = 2'b00;
      aop = 2'b00;
      r2l = (st != S_RESET) && (st != S_FAULT) &&
            (k == K_STUR || k == K_CBZ || k == K_CBNZ);
      case (st)
         S_FETCH:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
         S_DECODE: begin asb = 2'b11; ill = (k == K_ILL); end
         S_EXEC_R: begin asa = 1; aop = 2'b10; end
         S_WB_R:   rw = 1;
         S_ADDR:   begin asa = 1; asb = 2'b10; end
         S_MEM_RD: begin mr = 1; iord = 1; mdrw = rdy; end
         S_MEM_WB: begin rw = 1; m2r = 1; end
         S_MEM_WR: begin mw = 1; iord = 1; end
         S_CB:     begin asa = 1; aop = 2'b01; pwc = 1; ps = 1; pci = (k == K_CBNZ); end
         S_B:      begin pw = 1; ps = 1; end
         S_FAULT:  flt = 1;
         default: ;
      endcase
      return {pw, pwc, pci, ps, iord, mr, mw, irw, mdrw, m2r, rw, r2l, asa, asb, aop,
              ill, flt};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, expv);
      end
   endtask

   task automatic check_counters();
      chk("cycle_cnt4", 32'(cycle_cnt), 32'(cyc % 16));
      chk("instret_cnt4", 32'(instret_cnt), 32'(ret % 16));
      chk("cycle_cnt32", b_cycle_cnt, 32'(cyc));
      chk("instret_cnt32", b_instret_cnt, 32'(ret));
   endtask

   // ---------------- driver tasks ----------------
   // Starts at a falling edge, drives mem_ready, checks, advances one cycle.
   task automatic step(state_t st, logic rdy, logic retire_now);
      logic [18:0] e;
      mem_ready = rdy;
      #1;
      e = exp_outs(st, rdy, opcode);
      chk("state", 32'(state), 32'(st));
      chk("state32", 32'(b_state), 32'(st));
      chk("outs", 32'(obs_outs), 32'(e));
      chk("outs32", 32'(obs_outs_b), 32'(e));
      check_counters();
      @(posedge clk);
      if (st != S_FAULT) cyc++;
      if (retire_now) ret++;
      @(negedge clk);
   endtask

   task automatic mem_phase(state_t st, int waits, logic retire_on_ready);
      for (int i = 0; i < waits; i++) step(st, 1'b0, 1'b0);
      step(st, 1'b1, retire_on_ready);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'(($urandom_range(0, 1)));
      @(posedge clk);
      @(negedge clk);
      #1;
      cyc = 0;
      ret = 0;
      chk("rst_state", 32'(state), 32'(S_RESET));
      chk("rst_outs", 32'(obs_outs), 32'(0));
      check_counters();
      rst = 1'b0;
      step(S_RESET, 1'(($urandom_range(0, 1))), 1'b0);
   endtask

   task automatic run_instr(logic [10:0] op, int fw, int mw);
      int k;
      logic [31:0] start;
      k = classify(op);
      opcode = op;
      start = b_cycle_cnt;
      mem_phase(S_FETCH, fw, 1'b0);
      step(S_DECODE, 1'(($urandom_range(0, 1))), k == K_NOP);
      case (k)
         K_R: begin
            step(S_EXEC_R, 1'b1, 1'b0);
            step(S_WB_R, 1'b1, 1'b1);
         end
         K_LDUR: begin
            step(S_ADDR, 1'b0, 1'b0);
            mem_phase(S_MEM_RD, mw, 1'b0);
            step(S_MEM_WB, 1'b0, 1'b1);
         end
         K_STUR: begin
            step(S_ADDR, 1'b0, 1'b0);
            mem_phase(S_MEM_WR, mw, 1'b1);
         end
         K_CBZ, K_CBNZ: step(S_CB, 1'b1, 1'b1);
         K_B:           step(S_B, 1'b0, 1'b1);
         default: ;
      endcase
      chk("latency", b_cycle_cnt - start,
          32'(base_latency(k) + fw + ((k == K_LDUR || k == K_STUR) ? mw : 0)));
   endtask

   function automatic logic [10:0] rand_op(int k);
      logic [10:0] r;
      r = 11'($urandom);
      case (k)
         K_NOP:  return 11'd0;
         K_R:    return {1'b1, r[1:0], 4'b0101, r[2], 3'b000};
         K_LDUR: return 11'b11111000010;
         K_STUR: return 11'b11111000000;
         K_CBZ:  return {8'b10110100, r[2:0]};
         K_CBNZ: return {8'b10110101, r[2:0]};
         K_B:    return {6'b000101, r[4:0]};
         default: begin
            while (classify(r) != K_ILL) r = 11'($urandom);
            return r;
         end
      endcase
   endfunction

   function automatic int rand_wait();
      return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      @(negedge clk);
      do_reset();

      run_instr(11'b10001011000, 0, 0);   // ADD
      run_instr(11'b11111000010, 0, 3);   // LDUR, 3 wait cycles
      run_instr(11'b10110101000, 0, 0);   // CBNZ
      run_instr(11'b10110100011, 0, 0);   // CBZ
      run_instr(11'b11111111111, 0, 0);   // illegal
      run_instr(11'b00010100101, 2, 0);   // B with fetch waits
      run_instr(11'b11111000000, 0, 15);  // STUR, ready exactly at timeout
      run_instr(11'b11111000010, 15, 15); // LDUR, both accesses at timeout
      run_instr(11'd0, 0, 0);             // NOP

      for (int i = 0; i < 60; i++) begin
         int k;
         k = int'($urandom_range(0, 7));
         run_instr(rand_op(k), rand_wait(), rand_wait());
      end

      // fetch timeout: 15 wait cycles tolerated, the next unready cycle faults
      do_reset();
      opcode = rand_op(int'($urandom_range(0, 7)));
      for (int i = 0; i < 16; i++) step(S_FETCH, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(S_FAULT, 1'(($urandom_range(0, 1))), 1'b0);
      do_reset();

      // reset during a store wait aborts with no write strobe
      opcode = 11'b11111000000;
      step(S_FETCH, 1'b1, 1'b0);
      step(S_DECODE, 1'b1, 1'b0);
      step(S_ADDR, 1'b0, 1'b0);
      step(S_MEM_WR, 1'b0, 1'b0);
      step(S_MEM_WR, 1'b0, 1'b0);
      do_reset();

      // 16 retires wrap the 4-bit retired counter
      for (int i = 0; i < 16; i++) run_instr(11'd0, 0, 0);
      #1;
      chk("instret_wrap4", 32'(instret_cnt), 32'(0));
      chk("instret_nowrap32", b_instret_cnt, 32'(16));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle LEGv8 control unit: a state machine that sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several clocks instead of decoding one instruction per cycle. It covers R-type, LDUR/STUR, CBZ/CBNZ, B and NOP. It adds a memory ready handshake with a programmable timeout, illegal-opcode detection, and cycle/retired-instruction counters. It sits between the instruction register and a shared-memory multicycle datapath.

## Interface
- MEM_TIMEOUT, 15: max wait cycles for mem_ready per access; 0 disables the timeout.
- WAIT_W, 4: wait-counter width; must satisfy 2^WAIT_W > MEM_TIMEOUT.
- CNT_W, 32: width of the performance counters.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  11  IR[31:21], valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write, pc_write_cond, pc_cond_inv, pc_src  out  1 each  PC update controls; the datapath takes a branch when pc_write_cond & (zero ^ pc_cond_inv).
- ior_d, mem_read, mem_write, ir_write, mdr_write, mem_to_reg, reg_write, reg2loc, alu_src_a  out  1 each.
- alu_src_b  out  2  selects the ALU B input: 00 regB, 01 const 4, 10 D-offset, 11 branch offset<<2.
- alu_op  out  2  00 add, 01 pass-B/zero test, 10 funct decode.
- illegal  out  1  one-cycle pulse when an undefined opcode is seen in DECODE.
- fault  out  1  memory timeout; sticky until rst.
- state  out  4  current state encoding, for debug.
- cycle_cnt, instret_cnt  out  CNT_W  performance counters.

## Operation
- States: S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_CB, S_B, S_FAULT.
- Output decoding:
  - Outputs are a Moore decode of the state register.
  - Exceptions: ir_write and pc_write in S_FETCH, and mdr_write in S_MEM_RD, are state AND mem_ready.
  - reg2loc is decoded from opcode: 1 for STUR/CBZ/CBNZ, else 0. It is 0 in S_RESET.
  - Any output not listed for a state is 0.
- Opcode classes:
  - R-type: opcode[10]=1, [7:4]=0101, [2:0]=000.
  - STUR: 11111000000. LDUR: 11111000010.
  - CBZ: 10110100xxx. CBNZ: 10110101xxx.
  - B: 000101xxxxx.
  - NOP: all zero.
  - Anything else is illegal.
- Per-state outputs and transitions:
  - S_RESET: all outputs 0; next state S_FETCH.
  - S_FETCH: mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0. Waits for mem_ready, then goes to S_DECODE.
  - S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by class: R→S_EXEC_R, LDUR/STUR→S_ADDR, CBZ/CBNZ→S_CB, B→S_B, NOP→S_FETCH. Illegal→S_FETCH with illegal=1.
  - S_EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next S_WB_R.
  - S_WB_R: reg_write=1, mem_to_reg=0; next S_FETCH.
  - S_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next S_MEM_RD for LDUR, S_MEM_WR for STUR.
  - S_MEM_RD: mem_read=1, ior_d=1; waits for mem_ready, then S_MEM_WB.
  - S_MEM_WB: reg_write=1, mem_to_reg=1; next S_FETCH.
  - S_MEM_WR: mem_write=1, ior_d=1; waits for mem_ready, then S_FETCH.
  - S_CB: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1, pc_cond_inv=1 for CBNZ; next S_FETCH.
  - S_B: pc_write=1, pc_src=1; next S_FETCH.
  - S_FAULT: all outputs 0, fault=1; the only exit is rst.
- Wait counter:
  - Cleared on entry to each memory state; increments each cycle in a memory state with mem_ready=0.
  - If MEM_TIMEOUT≠0, reaching MEM_TIMEOUT with mem_ready=0 goes to S_FAULT.
  - mem_ready=1 on the same cycle the count reaches MEM_TIMEOUT counts as success; ready has priority.
- Counters:
  - cycle_cnt increments every cycle with rst=0, except in S_FAULT.
  - instret_cnt increments on the last cycle of each legal instruction, including NOP. Those cycles are S_WB_R, S_MEM_WB, S_MEM_WR (on ready), S_CB, S_B, and S_DECODE for NOP.
  - Illegal opcodes do not retire.
  - Both counters wrap modulo 2^CNT_W.

## Timing
- Reset: rst=1 forces state=S_RESET and clears both counters, the wait counter and fault at the same edge. All outputs are 0 while in S_RESET; the first fetch begins one cycle after rst falls.
- rst asserted mid-instruction or mid-wait aborts at the next edge, with no write strobes after it.
- Latency with zero-wait memory (mem_ready held high):
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/CBNZ/B: 3 cycles.
  - NOP or illegal: 2 cycles.
- Each wait cycle adds 1 cycle to the instruction's latency.
- Memory handshake: mem_read and mem_write stay asserted, and ior_d stays stable, from entry to a memory state until mem_ready is sampled high.

## Structure
- Package legv8_ctrl_pkg holds:
  - state enum;
  - opcode match constants and masks;
  - alu_src_b and alu_op encodings;
  - instruction-class enum.
- Sub-module legv8_opdecode: purely combinational. Maps opcode to {class, illegal, reg2loc, cond_inv} and is shared with the single-cycle control.
- The top level holds the state register, next-state logic, wait counter and perf counters.

## Test plan
- ADD (opcode 10001011000), mem_ready=1: states FETCH, DECODE, EXEC_R, WB_R; reg_write high in cycle 4 only; instret_cnt 0→1.
- LDUR (11111000010), mem_ready low 3 cycles in S_MEM_RD: mem_read and ior_d held 4 cycles, mdr_write on the ready cycle; total latency 8.
- CBNZ (10110101000): S_CB has pc_write_cond=1, pc_cond_inv=1, pc_src=1, alu_op=01; latency 3.
- Opcode 11111111111: illegal pulses 1 cycle in S_DECODE, then S_FETCH; instret_cnt unchanged; cycle_cnt +2.
- MEM_TIMEOUT=15, mem_ready stuck low in S_FETCH: S_FAULT after 15 wait cycles, fault sticky; rst pulse returns to S_RESET with counters=0.
- rst asserted during S_MEM_WR wait: the next cycle is S_RESET with mem_write=0; counter wrap checked at CNT_W=4, where the 16th retire returns instret_cnt to 0.
